// File: rtl/approx_err_monitor.sv
// Accuracy monitor for the approximate multiplier: exact shift-add product, |error|, running stats.
// Optional overestimate counter (output over_cnt) is enabled by defining APPROX_ERR_OVEREST_EN.
module approx_err_monitor #(
  parameter int unsigned OP_W   = 64,
  parameter int unsigned PROD_W = 128,
  parameter int unsigned ACC_W  = 144,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic [PROD_W-1:0] in_y,
  output logic              res_valid,
  output logic [PROD_W-1:0] last_err,
  output logic [PROD_W-1:0] err_max,
  output logic [ACC_W-1:0]  err_sum,
  output logic [CNT_W-1:0]  sample_cnt,
`ifdef APPROX_ERR_OVEREST_EN
  output logic [CNT_W-1:0]  over_cnt,
`endif
  output logic              stat_sat
);

  localparam int unsigned IterW = $clog2(OP_W + 1);
  // One spare bit above the wider of the two addends so overflow is always visible.
  localparam int unsigned SumW  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
  localparam logic [IterW-1:0] LastIter = IterW'(OP_W - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiff, StDone} state_e;

  state_e              state_q, state_d;
  logic [PROD_W-1:0]   mcand_q, mcand_d;
  logic [OP_W-1:0]     mplier_q, mplier_d;
  logic [PROD_W-1:0]   y_q, y_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic [IterW-1:0]    iter_q, iter_d;
  logic [PROD_W-1:0]   last_err_q, last_err_d;
  logic [PROD_W-1:0]   err_max_q, err_max_d;
  logic [ACC_W-1:0]    err_sum_q, err_sum_d;
  logic [CNT_W-1:0]    sample_cnt_q, sample_cnt_d;
  logic                stat_sat_q, stat_sat_d;
`ifdef APPROX_ERR_OVEREST_EN
  logic [CNT_W-1:0]    over_cnt_q, over_cnt_d;
`endif

  logic [PROD_W-1:0]   err_next;
  logic [SumW-1:0]     sum_full;
  logic                sum_ovf;
  logic                accept;

  assign in_ready = rst_n && (state_q == StIdle) && !clear;
  assign accept   = in_valid && in_ready;

  assign err_next = (prod_q >= y_q) ? (prod_q - y_q) : (y_q - prod_q);
  assign sum_full = SumW'(err_sum_q) + SumW'(err_next);
  assign sum_ovf  = |sum_full[SumW-1:ACC_W];

  always_comb begin
    state_d      = state_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    y_d          = y_q;
    prod_d       = prod_q;
    iter_d       = iter_q;
    last_err_d   = last_err_q;
    err_max_d    = err_max_q;
    err_sum_d    = err_sum_q;
    sample_cnt_d = sample_cnt_q;
    stat_sat_d   = stat_sat_q;
`ifdef APPROX_ERR_OVEREST_EN
    over_cnt_d   = over_cnt_q;
`endif

    case (state_q)
      StIdle: begin
        if (accept) begin
          mcand_d  = PROD_W'(in_a);
          mplier_d = in_b;
          y_d      = in_y;
          prod_d   = '0;
          iter_d   = '0;
          state_d  = StMul;
        end
      end
      StMul: begin
        if (mplier_q[0]) begin
          prod_d = prod_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (iter_q == LastIter) begin
          iter_d  = '0;
          state_d = StDiff;
        end else begin
          iter_d = iter_q + 1'b1;
        end
      end
      StDiff: begin
        state_d    = StDone;
        last_err_d = err_next;
        if (err_next > err_max_q) begin
          err_max_d = err_next;
        end
        if (sum_ovf) begin
          err_sum_d  = '1;
          stat_sat_d = 1'b1;
        end else begin
          err_sum_d = sum_full[ACC_W-1:0];
        end
        if (&sample_cnt_q) begin
          stat_sat_d = 1'b1;
        end else begin
          sample_cnt_d = sample_cnt_q + 1'b1;
        end
`ifdef APPROX_ERR_OVEREST_EN
        if (y_q > prod_q) begin
          if (&over_cnt_q) begin
            stat_sat_d = 1'b1;
          end else begin
            over_cnt_d = over_cnt_q + 1'b1;
          end
        end
`endif
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Clear wins over any accept or DONE-entry update in the same cycle.
    if (clear) begin
      state_d      = StIdle;
      iter_d       = '0;
      last_err_d   = '0;
      err_max_d    = '0;
      err_sum_d    = '0;
      sample_cnt_d = '0;
      stat_sat_d   = 1'b0;
`ifdef APPROX_ERR_OVEREST_EN
      over_cnt_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mcand_q      <= '0;
      mplier_q     <= '0;
      y_q          <= '0;
      prod_q       <= '0;
      iter_q       <= '0;
      last_err_q   <= '0;
      err_max_q    <= '0;
      err_sum_q    <= '0;
      sample_cnt_q <= '0;
      stat_sat_q   <= 1'b0;
`ifdef APPROX_ERR_OVEREST_EN
      over_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      y_q          <= y_d;
      prod_q       <= prod_d;
      iter_q       <= iter_d;
      last_err_q   <= last_err_d;
      err_max_q    <= err_max_d;
      err_sum_q    <= err_sum_d;
      sample_cnt_q <= sample_cnt_d;
      stat_sat_q   <= stat_sat_d;
`ifdef APPROX_ERR_OVEREST_EN
      over_cnt_q   <= over_cnt_d;
`endif
    end
  end

  assign res_valid  = (state_q == StDone);
  assign last_err   = last_err_q;
  assign err_max    = err_max_q;
  assign err_sum    = err_sum_q;
  assign sample_cnt = sample_cnt_q;
  assign stat_sat   = stat_sat_q;
`ifdef APPROX_ERR_OVEREST_EN
  assign over_cnt   = over_cnt_q;
`endif

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed bench for approx_err_monitor; a second narrow instance exercises saturation.
module tb_approx_err_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         clear;
  logic         in_valid;
  logic [63:0]  in_a;
  logic [63:0]  in_b;
  logic [127:0] in_y;

  logic         in_ready, res_valid, stat_sat;
  logic [127:0] last_err, err_max;
  logic [143:0] err_sum;
  logic [15:0]  sample_cnt;

  logic         s_ready, s_res_valid, s_sat;
  logic [127:0] s_last_err, s_err_max;
  logic [7:0]   s_err_sum;
  logic [1:0]   s_cnt;
`ifdef APPROX_ERR_OVEREST_EN
  logic [15:0]  over_cnt;
  logic [1:0]   s_over_cnt;
`endif

  approx_err_monitor u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_y       (in_y),
    .res_valid  (res_valid),
    .last_err   (last_err),
    .err_max    (err_max),
    .err_sum    (err_sum),
    .sample_cnt (sample_cnt),
`ifdef APPROX_ERR_OVEREST_EN
    .over_cnt   (over_cnt),
`endif
    .stat_sat   (stat_sat)
  );

  approx_err_monitor #(
    .OP_W   (64),
    .PROD_W (128),
    .ACC_W  (8),
    .CNT_W  (2)
  ) u_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (s_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_y       (in_y),
    .res_valid  (s_res_valid),
    .last_err   (s_last_err),
    .err_max    (s_err_max),
    .err_sum    (s_err_sum),
    .sample_cnt (s_cnt),
`ifdef APPROX_ERR_OVEREST_EN
    .over_cnt   (s_over_cnt),
`endif
    .stat_sat   (s_sat)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [63:0] a, input logic [63:0] b, input logic [127:0] y);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("accept_ready", in_ready, 1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_y     = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Returns the number of edges after the accept edge until res_valid is seen (0 = timeout).
  task automatic wait_res(output int lat);
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (res_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run(input logic [63:0] a, input logic [63:0] b, input logic [127:0] y);
    int lat;
    accept(a, b, y);
    wait_res(lat);
    chk("latency", lat, 65);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic count_res(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (res_valid) seen++;
    end
  endtask

  initial begin
    int seen;
    rst_n    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_y     = '0;
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_cnt", sample_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_sum", err_sum, 0);

    // Exact product
    run(64'd5, 64'd3, 128'd15);
    chk("exact_last_err", last_err, 0);
    chk("exact_err_max", err_max, 0);
    chk("exact_err_sum", err_sum, 0);
    chk("exact_cnt", sample_cnt, 1);
    @(posedge clk);
    #1;
    chk("pulse_one_cycle", res_valid, 0);
    chk("idle_after_done", in_ready, 1);

    // Underestimates
    pulse_clear();
    run(64'd1000, 64'd1000, 128'd999000);
    chk("under1_last_err", last_err, 1000);
    run(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 128'h1_FFFF_FFFF_FFFF_FF00);
    chk("under2_last_err", last_err, 144'hFE);
    chk("under_err_max", err_max, 1000);
    chk("under_err_sum", err_sum, 1254);
    chk("under_cnt", sample_cnt, 2);
    chk("under_sat", stat_sat, 0);

    // Over- then underestimate
    pulse_clear();
    run(64'd2, 64'd2, 128'd6);
    chk("over_last_err", last_err, 2);
`ifdef APPROX_ERR_OVEREST_EN
    chk("over_cnt1", over_cnt, 1);
`endif
    run(64'd3, 64'd3, 128'd8);
    chk("over2_last_err", last_err, 1);
    chk("over2_err_max", err_max, 2);
`ifdef APPROX_ERR_OVEREST_EN
    chk("over_cnt2", over_cnt, 1);
`endif

    // Saturation on the narrow instance, error 100 per sample
    pulse_clear();
    run(64'd10, 64'd10, 128'd0);
    chk("sat1_res_valid", s_res_valid, 1);
    chk("sat1_sum", s_err_sum, 100);
    chk("sat1_cnt", s_cnt, 1);
    chk("sat1_sat", s_sat, 0);
    run(64'd10, 64'd10, 128'd0);
    chk("sat2_sum", s_err_sum, 200);
    chk("sat2_cnt", s_cnt, 2);
    chk("sat2_sat", s_sat, 0);
    run(64'd10, 64'd10, 128'd0);
    chk("sat3_sum", s_err_sum, 255);
    chk("sat3_cnt", s_cnt, 3);
    chk("sat3_sat", s_sat, 1);
    run(64'd10, 64'd10, 128'd0);
    chk("sat4_sum", s_err_sum, 255);
    chk("sat4_cnt", s_cnt, 3);
    chk("sat4_sat", s_sat, 1);
    chk("sat4_last_err", s_last_err, 100);
    chk("main_sum_400", err_sum, 400);

    // Clear mid-MUL
    accept(64'd7, 64'd9, 128'd0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    #1;
    chk("clear_ready_low", in_ready, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    #1;
    chk("clear_ready_after", in_ready, 1);
    chk("clear_last_err", last_err, 0);
    chk("clear_err_max", err_max, 0);
    chk("clear_err_sum", err_sum, 0);
    chk("clear_cnt", sample_cnt, 0);
    chk("clear_sat", stat_sat, 0);
    count_res(80, seen);
    chk("clear_no_res", seen, 0);

    // Async reset while in DIFF
    run(64'd5, 64'd3, 128'd0);
    chk("pre_rst_last_err", last_err, 15);
    chk("pre_rst_cnt", sample_cnt, 1);
    accept(64'd6, 64'd6, 128'd0);
    repeat (64) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_last_err", last_err, 0);
    chk("arst_err_sum", err_sum, 0);
    chk("arst_cnt", sample_cnt, 0);
    chk("arst_ready", in_ready, 0);
    chk("arst_res_valid", res_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_res(80, seen);
    chk("arst_no_res", seen, 0);

    // Clear beats a coincident in_valid in IDLE
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_a     = 64'd4;
    in_b     = 64'd4;
    in_y     = 128'd0;
    #1;
    chk("clr_valid_ready", in_ready, 0);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("clr_valid_no_accept", in_ready, 1);
    count_res(80, seen);
    chk("clr_valid_no_res", seen, 0);
    chk("clr_valid_cnt", sample_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/approx_err_monitor.md
Name: approx_err_monitor

Overview:
- Sits directly downstream of the 64x64 approximate multiplier.
- Captures each operand pair (a, b) together with the approximate product y that the multiplier produced for it.
- Computes the exact product with a sequential shift-add datapath, forms the absolute error, and accumulates running error statistics.
- Used in silicon-characterisation runs and benches to quantify multiplier accuracy without a second full-array multiplier.

Parameters:
- OP_W, 64, operand width. Exact multiply takes OP_W cycles.
- PROD_W, 128, product/error width; must equal 2*OP_W.
- ACC_W, 144, width of the summed absolute error; saturating.
- CNT_W, 16, width of the sample counter; saturating.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous statistics clear / abort.
- in_valid  in  1  sample offered.
- in_ready  out  1  block can accept a sample.
- in_a  in  OP_W  operand a as fed to the multiplier.
- in_b  in  OP_W  operand b as fed to the multiplier.
- in_y  in  PROD_W  approximate product from the multiplier.
- res_valid  out  1  one-cycle pulse; statistics updated for a new sample.
- last_err  out  PROD_W  |exact - in_y| of the most recent sample.
- err_max  out  PROD_W  largest last_err since reset/clear.
- err_sum  out  ACC_W  sum of last_err since reset/clear, saturating.
- sample_cnt  out  CNT_W  samples completed since reset/clear, saturating.
- stat_sat  out  1  sticky; err_sum or sample_cnt has saturated.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - All outputs and internal registers go to 0. in_ready is 0 while rst_n=0.
  - Reset mid-operation discards the in-flight sample; no res_valid is produced for it.
- States:
  - IDLE → MUL on accept.
  - MUL → DIFF after OP_W cycles.
  - DIFF → DONE.
  - DONE → IDLE.
- Handshake:
  - in_ready = (state==IDLE) && !clear.
  - Accept happens on an edge where in_valid && in_ready; in_a, in_b and in_y are registered at that edge.
  - Inputs are ignored outside an accept edge.
- MUL:
  - prod starts at 0 and multiplicand at zero-extended a.
  - Each cycle, if the current LSB of b is 1, add the multiplicand to prod. Then shift the multiplicand left by 1 and b right by 1.
  - A 7-bit counter runs 0..OP_W-1; after the last iteration the state goes to DIFF.
  - Operands are unsigned.
- DIFF: last_err_next = (prod >= y) ? prod - y : y - prod, at full PROD_W width.
- DONE entry edge (the edge DIFF→DONE), all in one update:
  - last_err is loaded.
  - err_max = max(err_max, last_err_next).
  - err_sum += zero-extended last_err_next; if the sum would exceed 2^ACC_W-1 it holds all-ones and stat_sat is set.
  - sample_cnt increments; at all-ones it holds and stat_sat is set.
- DONE cycle: res_valid=1 for exactly that cycle; next edge returns to IDLE.
- Latency: res_valid is high during the cycle starting OP_W+1 edges after the accept edge (65 for OP_W=64). Throughput is one sample per OP_W+3 cycles.
- clear=1 at any edge:
  - State goes to IDLE and any in-flight sample is aborted with no res_valid.
  - last_err, err_max, err_sum, sample_cnt and stat_sat go to 0.
  - clear overrides a coincident accept and a coincident DONE update; the DONE update is discarded.
- Back-to-back: in_valid held high yields a new accept on the edge after DONE, i.e. the first IDLE cycle.
- Equal values: prod==y gives error 0; err_max is unchanged and sample_cnt still increments.

Optional Feature:
- Macro: APPROX_ERR_OVEREST_EN.
- When defined:
  - Adds output over_cnt (CNT_W, saturating, reset/clear 0). It increments on the DONE entry edge when y > prod, i.e. the multiplier overestimated.
  - over_cnt saturation also sets stat_sat.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Exact case: reset, then a=5, b=3, y=15 → res_valid 65 cycles after accept; last_err=0, err_max=0, err_sum=0, sample_cnt=1.
- Underestimate: a=1000, b=1000, y=999000, then a=0xFFFFFFFFFFFFFFFF, b=2, y=0x1FFFFFFFFFFFFFF00 → last_err=1000 then 0xFE; err_max=1000; err_sum=1254; sample_cnt=2.
- Overestimate with APPROX_ERR_OVEREST_EN: a=2, b=2, y=6 → last_err=2, over_cnt=1. A following sample a=3, b=3, y=8 → last_err=1, over_cnt stays 1, err_max=2.
- Saturation with ACC_W=8, CNT_W=2:
  - Four samples with error 100 each → err_sum=255 after the third sample and stays 255.
  - sample_cnt=3 after the third sample, stays 3 on the fourth.
  - stat_sat=1 from the third res_valid.
- Clear mid-MUL: accept a=7, b=9, y=0; assert clear 10 cycles later → no res_valid; in_ready=1 on the cycle after clear deasserts; all statistics read 0.
- Async reset mid-DIFF, plus clear priority:
  - Drop rst_n during the DIFF state → outputs are 0 immediately without waiting for clk; no res_valid.
  - Assert clear and in_valid together in IDLE → no accept; in_ready=0 that cycle.
